// File: rtl/placement_checker.sv
// Post-placement checker: verifies every node sits on a legal, matching grid cell,
// then recomputes Manhattan and 1-hop wirelength from the edge ROMs.
module placement_checker #(
    parameter int N_NODES = 11,
    parameter int N_EDGES = 37,
    parameter int GRID_N  = 6,
    parameter int DW      = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          ea_re_o,
    output logic          eb_re_o,
    output logic [DW-1:0] ea_addr_o,
    output logic [DW-1:0] eb_addr_o,
    input  logic [DW-1:0] ea_data_i,
    input  logic [DW-1:0] eb_data_i,
    output logic          px_re_o,
    output logic          py_re_o,
    output logic [DW-1:0] px_addr_o,
    output logic [DW-1:0] py_addr_o,
    input  logic [DW-1:0] px_data_i,
    input  logic [DW-1:0] py_data_i,
    output logic          grid_re_o,
    output logic [DW-1:0] grid_addr_o,
    input  logic [DW-1:0] grid_data_i,
    output logic [DW-1:0] unplaced_cnt_o,
    output logic [DW-1:0] range_err_cnt_o,
    output logic [DW-1:0] mismatch_cnt_o,
    output logic [DW-1:0] skipped_edges_o,
    output logic [DW-1:0] wirelength_o,
    output logic [DW-1:0] wirelength_1hop_o,
    output logic [DW-1:0] cycles_o
);

    typedef enum logic [4:0] {
        IDLE, N_RD, N_WAIT, N_CHK, G_RD, G_WAIT, G_CHK,
        E_RD, E_WAIT, E_LAT, PA_RD, PA_WAIT, PA_LAT,
        PB_RD, PB_WAIT, PB_LAT, ACC, DONE
    } state_t;

    localparam logic [DW-1:0]        ONE       = DW'(1);
    localparam logic [DW-1:0]        UNPLACED  = '1;
    localparam logic [DW-1:0]        LAST_NODE = DW'(N_NODES - 1);
    localparam logic [DW-1:0]        LAST_EDGE = DW'(N_EDGES - 1);
    localparam logic signed [DW-1:0] GRID_S    = DW'(GRID_N);
    localparam logic signed [DW-1:0] GMAX_S    = DW'(GRID_N - 1);
    localparam state_t               FIRST_ST  = (N_NODES > 0) ? N_RD : ((N_EDGES > 0) ? E_RD : DONE);
    localparam state_t               EDGE_ST   = (N_EDGES > 0) ? E_RD : DONE;

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic          edge_re_q, edge_re_d, pos_re_q, pos_re_d, grid_re_q, grid_re_d;
    logic [DW-1:0] edge_addr_q, edge_addr_d, pos_addr_q, pos_addr_d, grid_addr_q, grid_addr_d;
    logic [DW-1:0] k_q, k_d, e_q, e_d, cell_q, cell_d, a_q, a_d, b_q, b_d;
    logic [DW-1:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [DW-1:0] unpl_q, unpl_d, rng_q, rng_d, mis_q, mis_d, skip_q, skip_d;
    logic [DW-1:0] wl_q, wl_d, hop_q, hop_d, cyc_q, cyc_d;

    logic                 node_adv, edge_adv;
    logic signed [DW-1:0] x_s, y_s, dx_raw, dy_raw;
    logic [DW-1:0]        dx, dy;

    assign x_s    = px_data_i;
    assign y_s    = py_data_i;
    assign dx_raw = xa_q - xb_q;
    assign dy_raw = ya_q - yb_q;
    assign dx     = dx_raw[DW-1] ? (~dx_raw) + ONE : dx_raw;
    assign dy     = dy_raw[DW-1] ? (~dy_raw) + ONE : dy_raw;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        edge_re_d   = 1'b0;
        pos_re_d    = 1'b0;
        grid_re_d   = 1'b0;
        edge_addr_d = edge_addr_q;
        pos_addr_d  = pos_addr_q;
        grid_addr_d = grid_addr_q;
        k_d         = k_q;
        e_d         = e_q;
        cell_d      = cell_q;
        a_d         = a_q;
        b_d         = b_q;
        xa_d        = xa_q;
        ya_d        = ya_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        unpl_d      = unpl_q;
        rng_d       = rng_q;
        mis_d       = mis_q;
        skip_d      = skip_q;
        wl_d        = wl_q;
        hop_d       = hop_q;
        cyc_d       = busy_q ? cyc_q + ONE : cyc_q;
        node_adv    = 1'b0;
        edge_adv    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d  = 1'b1;
                    unpl_d  = '0;
                    rng_d   = '0;
                    mis_d   = '0;
                    skip_d  = '0;
                    wl_d    = '0;
                    hop_d   = '0;
                    cyc_d   = ONE;  // the accepting cycle counts as the first clock
                    k_d     = '0;
                    e_d     = '0;
                    state_d = FIRST_ST;
                end
            end
            N_RD: begin
                pos_re_d   = 1'b1;
                pos_addr_d = k_q;
                state_d    = N_WAIT;
            end
            N_WAIT: state_d = N_CHK;
            N_CHK: begin
                if (px_data_i == UNPLACED || py_data_i == UNPLACED) begin
                    unpl_d   = unpl_q + ONE;
                    node_adv = 1'b1;
                end else if (x_s < 0 || x_s > GMAX_S || y_s < 0 || y_s > GMAX_S) begin
                    rng_d    = rng_q + ONE;
                    node_adv = 1'b1;
                end else begin
                    cell_d  = x_s * GRID_S + y_s;
                    state_d = G_RD;
                end
            end
            G_RD: begin
                grid_re_d   = 1'b1;
                grid_addr_d = cell_q;
                state_d     = G_WAIT;
            end
            G_WAIT: state_d = G_CHK;
            G_CHK: begin
                if (grid_data_i != k_q)
                    mis_d = mis_q + ONE;
                node_adv = 1'b1;
            end
            E_RD: begin
                edge_re_d   = 1'b1;
                edge_addr_d = e_q;
                state_d     = E_WAIT;
            end
            E_WAIT: state_d = E_LAT;
            E_LAT: begin
                a_d     = ea_data_i;
                b_d     = eb_data_i;
                state_d = PA_RD;
            end
            PA_RD: begin
                pos_re_d   = 1'b1;
                pos_addr_d = a_q;
                state_d    = PA_WAIT;
            end
            PA_WAIT: state_d = PA_LAT;
            PA_LAT: begin
                xa_d    = px_data_i;
                ya_d    = py_data_i;
                state_d = PB_RD;
            end
            PB_RD: begin
                pos_re_d   = 1'b1;
                pos_addr_d = b_q;
                state_d    = PB_WAIT;
            end
            PB_WAIT: state_d = PB_LAT;
            PB_LAT: begin
                xb_d    = px_data_i;
                yb_d    = py_data_i;
                state_d = ACC;
            end
            ACC: begin
                if (xa_q == UNPLACED || ya_q == UNPLACED || xb_q == UNPLACED || yb_q == UNPLACED) begin
                    skip_d = skip_q + ONE;
                end else begin
                    // Coincident endpoints legitimately drive both costs negative.
                    wl_d  = wl_q + dx + dy - ONE;
                    hop_d = hop_q + (dx >> 1) + DW'(dx[0]) + (dy >> 1) + DW'(dy[0]) - ONE;
                end
                edge_adv = 1'b1;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (unpl_q == '0) && (rng_q == '0) && (mis_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (node_adv) begin
            if (k_q == LAST_NODE) begin
                e_d     = '0;
                state_d = EDGE_ST;
            end else begin
                k_d     = k_q + ONE;
                state_d = N_RD;
            end
        end
        if (edge_adv) begin
            if (e_q == LAST_EDGE) begin
                state_d = DONE;
            end else begin
                e_d     = e_q + ONE;
                state_d = E_RD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            edge_re_q   <= 1'b0;
            pos_re_q    <= 1'b0;
            grid_re_q   <= 1'b0;
            edge_addr_q <= '0;
            pos_addr_q  <= '0;
            grid_addr_q <= '0;
            k_q         <= '0;
            e_q         <= '0;
            cell_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            xa_q        <= '0;
            ya_q        <= '0;
            xb_q        <= '0;
            yb_q        <= '0;
            unpl_q      <= '0;
            rng_q       <= '0;
            mis_q       <= '0;
            skip_q      <= '0;
            wl_q        <= '0;
            hop_q       <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            edge_re_q   <= edge_re_d;
            pos_re_q    <= pos_re_d;
            grid_re_q   <= grid_re_d;
            edge_addr_q <= edge_addr_d;
            pos_addr_q  <= pos_addr_d;
            grid_addr_q <= grid_addr_d;
            k_q         <= k_d;
            e_q         <= e_d;
            cell_q      <= cell_d;
            a_q         <= a_d;
            b_q         <= b_d;
            xa_q        <= xa_d;
            ya_q        <= ya_d;
            xb_q        <= xb_d;
            yb_q        <= yb_d;
            unpl_q      <= unpl_d;
            rng_q       <= rng_d;
            mis_q       <= mis_d;
            skip_q      <= skip_d;
            wl_q        <= wl_d;
            hop_q       <= hop_d;
            cyc_q       <= cyc_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign ea_re_o           = edge_re_q;
    assign eb_re_o           = edge_re_q;
    assign ea_addr_o         = edge_addr_q;
    assign eb_addr_o         = edge_addr_q;
    assign px_re_o           = pos_re_q;
    assign py_re_o           = pos_re_q;
    assign px_addr_o         = pos_addr_q;
    assign py_addr_o         = pos_addr_q;
    assign grid_re_o         = grid_re_q;
    assign grid_addr_o       = grid_addr_q;
    assign unplaced_cnt_o    = unpl_q;
    assign range_err_cnt_o   = rng_q;
    assign mismatch_cnt_o    = mis_q;
    assign skipped_edges_o   = skip_q;
    assign wirelength_o      = wl_q;
    assign wirelength_1hop_o = hop_q;
    assign cycles_o          = cyc_q;

endmodule

// File: tb/tb_placement_checker.sv
// Directed bench for placement_checker: small 3-node / 2-edge memories modelled here,
// results compared against hand-computed costs, counters and latencies.
module tb_placement_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic        ea_re, eb_re, px_re, py_re, grid_re;
    logic [31:0] ea_addr, eb_addr, px_addr, py_addr, grid_addr;
    logic [31:0] ea_data, eb_data, px_data, py_data, grid_data;
    logic [31:0] unplaced_cnt, range_err_cnt, mismatch_cnt, skipped_edges;
    logic [31:0] wirelength, wirelength_1hop, cycles;

    logic [31:0] px_mem [0:7];
    logic [31:0] py_mem [0:7];
    logic [31:0] grid_mem [0:63];
    logic [31:0] ea_mem [0:1];
    logic [31:0] eb_mem [0:1];

    logic clr_cnt = 1'b0;
    int   grid_reads, pos_reads, done_pulses;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    placement_checker #(.N_NODES(3), .N_EDGES(2), .GRID_N(6), .DW(32)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .ea_re_o(ea_re), .eb_re_o(eb_re), .ea_addr_o(ea_addr), .eb_addr_o(eb_addr),
        .ea_data_i(ea_data), .eb_data_i(eb_data),
        .px_re_o(px_re), .py_re_o(py_re), .px_addr_o(px_addr), .py_addr_o(py_addr),
        .px_data_i(px_data), .py_data_i(py_data),
        .grid_re_o(grid_re), .grid_addr_o(grid_addr), .grid_data_i(grid_data),
        .unplaced_cnt_o(unplaced_cnt), .range_err_cnt_o(range_err_cnt),
        .mismatch_cnt_o(mismatch_cnt), .skipped_edges_o(skipped_edges),
        .wirelength_o(wirelength), .wirelength_1hop_o(wirelength_1hop), .cycles_o(cycles)
    );

    // Registered-read memories: strobe sampled on one edge, data valid after it.
    always @(posedge clk) begin
        if (ea_re) ea_data <= ea_mem[ea_addr[0]];
        if (eb_re) eb_data <= eb_mem[eb_addr[0]];
        if (px_re) px_data <= px_mem[px_addr[2:0]];
        if (py_re) py_data <= py_mem[py_addr[2:0]];
        if (grid_re) grid_data <= grid_mem[grid_addr[5:0]];
    end

    always @(posedge clk) begin
        if (clr_cnt) begin
            grid_reads  <= 0;
            pos_reads   <= 0;
            done_pulses <= 0;
        end else begin
            if (grid_re) grid_reads <= grid_reads + 1;
            if (px_re && py_re && px_addr == py_addr) pos_reads <= pos_reads + 1;
            if (done) done_pulses <= done_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_pos(input int n, input int x, input int y);
        px_mem[n] = x;
        py_mem[n] = y;
    endtask

    task automatic load_legal();
        for (int i = 0; i < 64; i++) grid_mem[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) set_pos(i, -1, -1);
        set_pos(0, 0, 0);
        set_pos(1, 0, 3);
        set_pos(2, 2, 3);
        grid_mem[0]  = 0;
        grid_mem[3]  = 1;
        grid_mem[15] = 2;
        ea_mem[0] = 0; eb_mem[0] = 1;
        ea_mem[1] = 1; eb_mem[1] = 2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        clr_cnt = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " done"}, got, 1'b1);
    endtask

    task automatic check_run(input string tag, input int unpl, input int rng, input int mis,
                             input int skip, input int wl, input int hop, input int cyc,
                             input int pss, input int greads);
        $display("%s: unpl=%0d rng=%0d mis=%0d skip=%0d wl=%0d hop=%0d cyc=%0d pass=%0b",
                 tag, unplaced_cnt, range_err_cnt, mismatch_cnt, skipped_edges,
                 $signed(wirelength), $signed(wirelength_1hop), cycles, pass);
        check({tag, " unplaced"}, unplaced_cnt, unpl);
        check({tag, " range_err"}, range_err_cnt, rng);
        check({tag, " mismatch"}, mismatch_cnt, mis);
        check({tag, " skipped"}, skipped_edges, skip);
        check({tag, " wirelength"}, wirelength, wl);
        check({tag, " wl_1hop"}, wirelength_1hop, hop);
        check({tag, " cycles"}, cycles, cyc);
        check({tag, " pass"}, {31'd0, pass}, pss);
        check({tag, " grid_reads"}, grid_reads, greads);
        check({tag, " pos_reads"}, pos_reads, 7);
        check({tag, " busy_low"}, {31'd0, busy}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 0);
        check({tag, " done"}, {31'd0, done}, 0);
        check({tag, " pass"}, {31'd0, pass}, 0);
        check({tag, " strobes"}, {27'd0, ea_re, eb_re, px_re, py_re, grid_re}, 0);
        check({tag, " unplaced"}, unplaced_cnt, 0);
        check({tag, " range_err"}, range_err_cnt, 0);
        check({tag, " mismatch"}, mismatch_cnt, 0);
        check({tag, " skipped"}, skipped_edges, 0);
        check({tag, " wirelength"}, wirelength, 0);
        check({tag, " wl_1hop"}, wirelength_1hop, 0);
        check({tag, " cycles"}, cycles, 0);
    endtask

    initial begin
        load_legal();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // S1: legal placement
        pulse_start();
        check("S1 busy", {31'd0, busy}, 1);
        wait_done("S1");
        check_run("S1", 0, 0, 0, 0, 3, 1, 40, 1, 3);

        // S2: node 2 unplaced, its edge skipped
        set_pos(2, -1, -1);
        grid_mem[15] = 32'hFFFF_FFFF;
        pulse_start();
        wait_done("S2");
        check_run("S2", 1, 0, 0, 1, 2, 1, 37, 0, 2);

        // S3: node 1 off-grid at (6,0), no grid read for it
        load_legal();
        set_pos(1, 6, 0);
        pulse_start();
        wait_done("S3");
        check_run("S3", 0, 1, 0, 0, 11, 5, 37, 0, 2);

        // S4: grid[0] claims node 1 while node 0 sits there
        load_legal();
        grid_mem[0] = 1;
        pulse_start();
        wait_done("S4");
        check_run("S4", 0, 0, 1, 0, 3, 1, 40, 0, 3);

        // S5: second edge has coincident endpoints at (4,4)
        load_legal();
        set_pos(2, 4, 4);
        grid_mem[15] = 32'hFFFF_FFFF;
        grid_mem[28] = 2;
        ea_mem[1] = 2; eb_mem[1] = 2;
        pulse_start();
        wait_done("S5");
        check_run("S5", 0, 0, 0, 0, 1, 0, 40, 1, 3);

        // S5b: both edges coincident, costs go negative
        ea_mem[0] = 2; eb_mem[0] = 2;
        pulse_start();
        wait_done("S5b");
        check_run("S5b", 0, 0, 0, 0, -2, -2, 40, 1, 3);

        // S6: start while busy is ignored
        load_legal();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("S6");
        check_run("S6", 0, 0, 0, 0, 3, 1, 40, 1, 3);
        repeat (3) @(negedge clk);
        check("S6 no restart", {31'd0, busy}, 0);
        check("S6 one done", done_pulses, 1);

        // S7: reset in the middle of the edge phase
        pulse_start();
        repeat (24) @(negedge clk);
        check("S7 busy before reset", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("S7 after reset");
        repeat (5) @(negedge clk);
        check("S7 stays idle", {31'd0, busy}, 0);
        check("S7 no done", done_pulses, 0);

        // S8: fresh run reproduces S1
        pulse_start();
        wait_done("S8");
        check_run("S8", 0, 0, 0, 0, 3, 1, 40, 1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/placement_checker.md
Name: placement_checker

Overview:
- Post-placement checker/evaluator. Sits directly downstream of the placement engine.
- Runs after the engine finishes. Scans the final pos_X/pos_Y and grid RAMs plus the edge ROMs (ea/eb).
- Checks that the placement is legal, then recomputes Manhattan and 1-hop wirelength independently.
- The top level uses its pass flag and costs to accept or reject a benchmark run.

Parameters:
- N_NODES, 11, number of nodes (depth of the pos_X/pos_Y RAMs).
- N_EDGES, 37, number of edges (entries in the ea/eb ROMs).
- GRID_N, 6, grid side; grid address = x*GRID_N + y.
- DW, 32, data/address width; all signed two's complement.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a check when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  result flag; see Behaviour.
- ea_re / eb_re  out  1  read strobes for the edge ROMs.
- ea_addr / eb_addr  out  DW  edge index.
- ea_data / eb_data  in  DW  source / sink node id.
- px_re / py_re  out  1  read strobes for the position RAMs.
- px_addr / py_addr  out  DW  node id.
- px_data / py_data  in  DW  x / y position (-1 = unplaced).
- grid_re  out  1  grid RAM read strobe.
- grid_addr  out  DW  cell index.
- grid_data  in  DW  occupying node id (-1 = empty).
- unplaced_cnt, range_err_cnt, mismatch_cnt, skipped_edges  out  DW  error and skip counters.
- wirelength, wirelength_1hop  out  DW  accumulated costs.
- cycles  out  DW  clocks from start accepted to done.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All strobes, busy, done and pass = 0. All counters and costs = 0. Reset mid-run aborts immediately; no done pulse.
- Read protocol: strobes are registered and asserted for exactly one cycle.
  - A memory samples the strobe on the next edge; its data is valid one edge later.
  - Every read is therefore ISSUE -> WAIT -> USE (data consumed 2 cycles after the issue state).
  - At most one outstanding read per memory. px/py are always read as a pair with the same address.
- start is ignored while busy.
- On an accepted start: clear all counters, costs and cycles, and set k=0.
- cycles increments every cycle while busy.
- Node phase, for k in 0..N_NODES-1:
  - N_RD: read px/py[k]. N_WAIT. N_CHK:
    - if x==-1 or y==-1: unplaced_cnt++, go to next k;
    - else if x or y outside [0,GRID_N-1]: range_err_cnt++, go to next k;
    - else latch cell = x*GRID_N+y (signed multiply, low DW bits) and go to G_RD.
  - G_RD: read grid[cell]. G_WAIT. G_CHK: if grid_data != k then mismatch_cnt++.
  - After k==N_NODES-1, set e=0 and go to the edge phase.
- Edge phase, for e in 0..N_EDGES-1:
  - E_RD: read ea/eb[e]. E_WAIT. Latch a, b.
  - PA_RD: read pos[a]. PA_WAIT. Latch xa, ya.
  - PB_RD: read pos[b]. PB_WAIT. Latch xb, yb.
  - ACC:
    - if any coordinate == -1: skipped_edges++;
    - else dx=|xa-xb|, dy=|ya-yb| (negation = invert+1), then:
      - wirelength += dx+dy-1;
      - wirelength_1hop += (dx>>1)+dx[0] + (dy>>1)+dy[0] - 1.
  - Costs are signed and may go negative, e.g. -1 for coincident endpoints. No saturation; wrap mod 2^DW.
- DONE: pulse done for 1 cycle, drop busy, return to IDLE.
  - pass = 1 iff unplaced_cnt, range_err_cnt and mismatch_cnt are all 0.
  - All result outputs hold their values until the next accepted start.
- N_EDGES=0: edge phase skipped, costs stay 0. N_NODES=0: node phase skipped.
- Node ids out of [0,N_NODES-1] from the edge ROMs are not checked; the addresses are passed through to the RAMs unchanged.
- Duplicate grid occupancy is caught indirectly: the node that lost the cell reports a mismatch.
- Latency with no skips:
  - node k costs 3 cycles if rejected, 6 if it goes through the grid check;
  - edge e costs 10 cycles;
  - plus 1 (start) + 1 (DONE).

Test Plan:
- Legal 3-node placement, N_NODES=3, N_EDGES=2, GRID_N=6: nodes (0,0),(0,3),(2,3), grid entries consistent; edges 0-1, 1-2 -> pass=1, wirelength=(3-1)+(2-1)=3, wirelength_1hop=(2-1)+(1-1)=1, skipped_edges=0.
- Node 2 pos=(-1,-1), same edges -> unplaced_cnt=1, pass=0, skipped_edges=1, wirelength=2.
- Node 1 pos=(6,0) -> range_err_cnt=1, pass=0; no grid read is issued for node 1.
- grid[0] holds 1 while node 0 sits at (0,0) -> mismatch_cnt=1, pass=0.
- Edge with coincident endpoints (both at (4,4)) -> wirelength and wirelength_1hop each decrease by 1.
- start pulsed while busy is ignored; reset asserted mid edge phase -> next cycle all outputs are 0 and state is IDLE; a fresh start then reproduces scenario 1 exactly, including cycles = 1+3*6+2*10+1 = 40.
